// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment constants and hex glyph table for the 7-segment scan driver.
//   SEG_A..SEG_G : bit position of each segment inside a seg_n vector
//   SEG_OFF      : all segments dark (active-low)
//   GLYPH        : 16-entry active-low glyph table, indexed by hex code
//   pend_state_t : states of the update-pending machine
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] M_A = 7'(1) << SEG_A;
    localparam logic [6:0] M_B = 7'(1) << SEG_B;
    localparam logic [6:0] M_C = 7'(1) << SEG_C;
    localparam logic [6:0] M_D = 7'(1) << SEG_D;
    localparam logic [6:0] M_E = 7'(1) << SEG_E;
    localparam logic [6:0] M_F = 7'(1) << SEG_F;
    localparam logic [6:0] M_G = 7'(1) << SEG_G;

    // Entry 15 (F) first, entry 0 last; each glyph lists its lit segments.
    localparam logic [15:0][6:0] GLYPH = {
        ~(M_A | M_E | M_F | M_G),
        ~(M_A | M_D | M_E | M_F | M_G),
        ~(M_B | M_C | M_D | M_E | M_G),
        ~(M_A | M_D | M_E | M_F),
        ~(M_C | M_D | M_E | M_F | M_G),
        ~(M_A | M_B | M_C | M_E | M_F | M_G),
        ~(M_A | M_B | M_C | M_D | M_F | M_G),
        ~(M_A | M_B | M_C | M_D | M_E | M_F | M_G),
        ~(M_A | M_B | M_C),
        ~(M_A | M_C | M_D | M_E | M_F | M_G),
        ~(M_A | M_C | M_D | M_F | M_G),
        ~(M_B | M_C | M_F | M_G),
        ~(M_A | M_B | M_C | M_D | M_G),
        ~(M_A | M_B | M_D | M_E | M_G),
        ~(M_B | M_C),
        ~(M_A | M_B | M_C | M_D | M_E | M_F)
    };

    typedef enum logic {IDLE, PEND} pend_state_t;

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex-to-7-segment decoder with blanking and decimal point.
//   hex   : 4-bit hex code
//   blank : forces all segments and the point dark
//   point : decimal point request, active-high
//   seg_n : active-low segments, bit0=a .. bit6=g
//   dp_n  : active-low decimal point
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    input  logic       point,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    assign seg_n = blank ? SEG_OFF : GLYPH[hex];
    assign dp_n  = blank | ~point;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed DIGITS-digit 7-segment driver with frame-synchronous updates.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : strobe capturing hex_in/point_in/blank_in into the shadow registers
//   hex_in      : 4 bits per digit, digit k at [4k+3:4k]
//   point_in    : decimal point request per digit
//   blank_in    : blank request per digit
//   pending     : shadow holds data not yet committed to the display
//   seg_n, dp_n : registered active-low segments and decimal point
//   an_n        : registered active-low one-cold digit select
//   frame_tick  : one-cycle pulse coinciding with the first cycle of digit 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic                  pending,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  boundary;
    logic                  commit;
    pend_state_t           state;
    pend_state_t           state_nxt;
    logic [4*DIGITS-1:0]   sh_hex;
    logic [4*DIGITS-1:0]   act_hex;
    logic [DIGITS-1:0]     sh_pt;
    logic [DIGITS-1:0]     act_pt;
    logic [DIGITS-1:0]     sh_blank;
    logic [DIGITS-1:0]     act_blank;
    logic [6:0]            dec_seg;
    logic                  dec_dp;

    assign tick     = cnt == CW'(SCAN_DIV - 1);
    assign boundary = tick && idx == IW'(DIGITS - 1);
    assign pending  = state == PEND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A load wins over the commit's return to IDLE; the commit itself still
    // happens because it reads the shadow before this edge's capture.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        if (boundary && state == PEND) begin
            commit    = 1'b1;
            state_nxt = IDLE;
        end
        if (load)
            state_nxt = PEND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hex   <= '0;
            sh_pt    <= '0;
            sh_blank <= '1;
        end else if (load) begin
            sh_hex   <= hex_in;
            sh_pt    <= point_in;
            sh_blank <= blank_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_hex   <= '0;
            act_pt    <= '0;
            act_blank <= '1;
        end else if (commit) begin
            act_hex   <= sh_hex;
            act_pt    <= sh_pt;
            act_blank <= sh_blank;
        end
    end

    hex7seg_decode u_dec (
        .hex   (act_hex[{idx, 2'b00} +: 4]),
        .blank (act_blank[idx]),
        .point (act_pt[idx]),
        .seg_n (dec_seg),
        .dp_n  (dec_dp)
    );

    // frame_tick is derived from the same stage as an_n so it lines up with digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= dec_seg;
            dp_n       <= dec_dp;
            an_n       <= ~(DIGITS'(1) << idx);
            frame_tick <= cnt == '0 && idx == '0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_driver;

    typedef struct {
        int         frame;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  point_in = '0;
    logic [3:0]  blank_in = '0;
    logic        pending;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    exp_t q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   fc = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .hex_in     (hex_in),
        .point_in   (point_in),
        .blank_in   (blank_in),
        .pending    (pending),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input int f, input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.frame = f;
            e.an    = ~(4'b0001 << d);
            e.seg   = b[d] ? 7'h7F : glyph(h[4*d +: 4]);
            e.dp    = b[d] ? 1'b1 : ~p[d];
            e.ft    = d == 0;
            q.push_back(e);
        end
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
        hex_in   = h;
        point_in = p;
        blank_in = b;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    task automatic sync_frame();
        int f0;
        int n;
        f0 = fc;
        n  = 0;
        while (fc == f0 && n < 40) begin
            step();
            n++;
        end
        if (fc == f0) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame start after %0d cycles, expected one within 40", n);
        end
    endtask

    // Monitor: a digit slot is presented whenever an_n changes; a change to 1110 starts a frame.
    initial begin
        logic [3:0] prev_an;
        logic       have_prev;
        int         cyc;
        int         last;
        exp_t       e;
        prev_an   = 4'b1111;
        have_prev = 1'b0;
        cyc       = 0;
        last      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
                prev_an   = an_n;
            end else begin
                cyc++;
                if (frame_tick)
                    check("frame_tick_align", {28'd0, an_n}, 32'hE);
                if (an_n !== prev_an) begin
                    if (an_n == 4'b1110)
                        fc++;
                    if (have_prev)
                        check("slot_length", cyc - last, 4);
                    have_prev = 1'b1;
                    last      = cyc;
                    while (q.size() > 0 && q[0].frame < fc) begin
                        e = q.pop_front();
                        check("missed_slot", {28'd0, e.an}, 32'hF);
                    end
                    if (q.size() > 0 && q[0].frame == fc) begin
                        e = q.pop_front();
                        check($sformatf("frame%0d_an%b", fc, e.an),
                              {18'd0, an_n, seg_n, dp_n, frame_tick},
                              {18'd0, e.an, e.seg, e.dp, e.ft});
                    end
                end
                prev_an = an_n;
            end
        end
    end

    initial begin
        repeat (3) step();
        check("reset_seg_n", {25'd0, seg_n}, 32'h7F);
        check("reset_dp_an_ft_pend", {28'd0, dp_n, an_n == 4'hF, frame_tick, pending}, 32'b1100);
        push_frame(1, 16'h0000, 4'h0, 4'hF);
        push_frame(2, 16'h0000, 4'h0, 4'hF);
        rst_n = 1'b1;
        sync_frame();
        sync_frame();
        check("idle_pending", {31'd0, pending}, 0);

        // Basic load: digits 1,7,b,4 with the point on digit 1.
        repeat (2) step();
        do_load(16'h4B71, 4'b0010, 4'b0000);
        check("pend_after_load", {31'd0, pending}, 1);
        push_frame(fc + 1, 16'h4B71, 4'b0010, 4'b0000);
        sync_frame();
        check("pend_cleared", {31'd0, pending}, 0);

        // Two loads in one frame: last one wins.
        repeat (2) step();
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (3) step();
        do_load(16'h8888, 4'b0000, 4'b0000);
        push_frame(fc + 1, 16'h8888, 4'b0000, 4'b0000);
        sync_frame();

        // Load landing exactly on the boundary edge while pending.
        repeat (2) step();
        do_load(16'h2222, 4'b0000, 4'b0000);
        push_frame(fc + 1, 16'h2222, 4'b0000, 4'b0000);
        push_frame(fc + 2, 16'h5555, 4'b0000, 4'b0000);
        repeat (11) step();
        do_load(16'h5555, 4'b0000, 4'b0000);
        check("pend_across_boundary", {31'd0, pending}, 1);
        sync_frame();
        check("pend_still_set", {31'd0, pending}, 1);
        sync_frame();
        check("pend_after_second_commit", {31'd0, pending}, 0);

        // Blanked digit keeps its anode; other glyphs A, d, F, 3, 9, C, E.
        repeat (2) step();
        do_load(16'hE6C9, 4'b0100, 4'b0100);
        push_frame(fc + 1, 16'hE6C9, 4'b0100, 4'b0100);
        sync_frame();
        repeat (2) step();
        do_load(16'hFDA3, 4'b1001, 4'b0000);
        push_frame(fc + 1, 16'hFDA3, 4'b1001, 4'b0000);
        sync_frame();

        // Reset mid-frame with an update pending: it must be discarded.
        repeat (2) step();
        do_load(16'h8888, 4'b1111, 4'b0000);
        check("pend_before_reset", {31'd0, pending}, 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_seg_n", {25'd0, seg_n}, 32'h7F);
        check("async_reset_dp_an_ft_pend", {28'd0, dp_n, an_n == 4'hF, frame_tick, pending}, 32'b1100);
        q.delete();
        repeat (3) step();
        push_frame(fc + 1, 16'h0000, 4'h0, 4'hF);
        push_frame(fc + 2, 16'h0000, 4'h0, 4'hF);
        rst_n = 1'b1;
        sync_frame();
        check("pend_after_reset", {31'd0, pending}, 0);
        sync_frame();
        sync_frame();
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
